vga_rx: RTL and testbench

Receiving end of the VGA link driven by `vga_ctrl`. The block samples `hsync`, `vsync` and `vga_rgb` on the pixel clock and regenerates the pixel coordinates and pixel data. It checks the incoming line and frame lengths against the 640x480@60 timing parameters and declares lock after a run of consistent frames. It sits in loopback and verification builds, directly behind the `vga_char` outputs, and feeds checkers and capture logic.

---
 rtl/vga_pkg.sv | 18 +
 rtl/vga_sync_edge.sv | 25 ++
 rtl/vga_rx.sv | 182 ++++++++++++++++++
 tb/tb_vga_rx.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants and the vga_rx lock-FSM state encoding.
package vga_pkg;

  localparam int VGA_H_SYNC      = 96;
  localparam int VGA_H_ACT_START = 144;
  localparam int VGA_H_VALID     = 640;
  localparam int VGA_H_TOTAL     = 800;
  localparam int VGA_V_ACT_START = 35;
  localparam int VGA_V_VALID     = 480;
  localparam int VGA_V_TOTAL     = 525;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } rx_state_e;

endpackage

// File: rtl/vga_sync_edge.sv
// Input register for one sync line plus leading-edge detector on the registered sample.
module vga_sync_edge #(
  parameter bit POL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sync_i,
  output logic edge_o
);

  logic s_q, prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s_q    <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s_q    <= sync_i;
      prev_q <= s_q;
    end
  end

  assign edge_o = (s_q == POL) && (prev_q != POL);

endmodule

// File: rtl/vga_rx.sv
// VGA receiver: regenerates pixel coordinates from hsync/vsync, measures line/frame
// lengths and locks after LOCK_FRAMES good frames. VGA_RX_STAT_EN adds h_meas/v_meas/err_cnt.
module vga_rx import vga_pkg::*; #(
  parameter int H_SYNC      = VGA_H_SYNC,
  parameter int H_ACT_START = VGA_H_ACT_START,
  parameter int H_VALID     = VGA_H_VALID,
  parameter int H_TOTAL     = VGA_H_TOTAL,
  parameter int V_ACT_START = VGA_V_ACT_START,
  parameter int V_VALID     = VGA_V_VALID,
  parameter int V_TOTAL     = VGA_V_TOTAL,
  parameter bit SYNC_POL    = 1'b1,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        vga_clk,
  input  logic        sys_rst,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [15:0] vga_rgb,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [15:0] pix_data,
  output logic        pix_valid,
  output logic        frame_start,
  output logic        locked,
  output logic        sync_err
`ifdef VGA_RX_STAT_EN
  ,
  output logic [10:0] h_meas,
  output logic [9:0]  v_meas,
  output logic [7:0]  err_cnt
`endif
);

  if (H_SYNC >= H_ACT_START || H_ACT_START + H_VALID > H_TOTAL ||
      V_ACT_START + V_VALID > V_TOTAL) begin : g_bad_cfg
    $error("vga_rx: inconsistent timing parameters");
  end

  logic        h_edge, v_edge;
  logic [15:0] rgb_q;

  vga_sync_edge #(.POL(SYNC_POL)) u_hs (
    .clk_i(vga_clk), .rst_i(sys_rst), .sync_i(hsync), .edge_o(h_edge));
  vga_sync_edge #(.POL(SYNC_POL)) u_vs (
    .clk_i(vga_clk), .rst_i(sys_rst), .sync_i(vsync), .edge_o(v_edge));

  always_ff @(posedge vga_clk) begin
    if (sys_rst) rgb_q <= '0;
    else         rgb_q <= vga_rgb;
  end

  // cnt_*_q hold the position of the previous stage-1 sample; cnt_*_d is the
  // position of the sample now in rgb_q, so coordinates line up with the data.
  logic [10:0] cnt_h_q, cnt_h_d;
  logic [9:0]  cnt_v_q, cnt_v_d;
  logic        v_pend_q, v_pend_d;
  logic [11:0] h_len;
  logic [10:0] v_len;
  logic        h_sat;

  assign h_len = {1'b0, cnt_h_q} + 12'd1;
  assign v_len = {1'b0, cnt_v_q} + 11'd1;
  assign h_sat = (cnt_h_q == '1);

  always_comb begin
    cnt_h_d  = h_edge ? '0 : (h_sat ? cnt_h_q : h_len[10:0]);
    cnt_v_d  = cnt_v_q;
    v_pend_d = v_pend_q;
    if (v_edge) begin
      cnt_v_d  = '0;
      v_pend_d = !h_edge;
    end else if (h_edge) begin
      cnt_v_d  = v_pend_q ? '0 : (v_len[10] ? cnt_v_q : v_len[9:0]);
      v_pend_d = 1'b0;
    end
  end

  rx_state_e   state_q;
  logic [7:0]  good_cnt_q;
  logic        lines_ok_q;
  logic        line_bad, frame_good, err_now, lock_now, lock_nxt, act, emit;
  logic [9:0]  pix_x_nxt, pix_y_nxt;

  assign line_bad   = h_edge && (h_len != 12'(H_TOTAL));
  assign frame_good = (v_len == 11'(V_TOTAL)) && lines_ok_q && !line_bad;
  assign err_now    = (state_q == LOCKED) &&
                      (line_bad || (v_edge && !frame_good) || h_sat);
  assign lock_now   = (state_q == MEASURE) && v_edge && frame_good &&
                      (good_cnt_q + 8'd1 == 8'(LOCK_FRAMES));
  assign lock_nxt   = ((state_q == LOCKED) && !err_now) || lock_now;

  assign act  = (cnt_h_d >= 11'(H_ACT_START)) && (cnt_h_d < 11'(H_ACT_START + H_VALID)) &&
                (cnt_v_d >= 10'(V_ACT_START)) && (cnt_v_d < 10'(V_ACT_START + V_VALID));
  assign emit = lock_nxt && act;
  assign pix_x_nxt = 10'(cnt_h_d - 11'(H_ACT_START));
  assign pix_y_nxt = cnt_v_d - 10'(V_ACT_START);

  logic [9:0]  pix_x_q, pix_y_q;
  logic [15:0] pix_data_q;
  logic        pix_valid_q, frame_start_q, locked_q, sync_err_q;

  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      state_q       <= SEARCH;
      good_cnt_q    <= '0;
      lines_ok_q    <= 1'b0;
      cnt_h_q       <= '0;
      cnt_v_q       <= '0;
      v_pend_q      <= 1'b0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      pix_data_q    <= '0;
      pix_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      locked_q      <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      cnt_h_q       <= cnt_h_d;
      cnt_v_q       <= cnt_v_d;
      v_pend_q      <= v_pend_d;
      pix_valid_q   <= emit;
      frame_start_q <= emit && (pix_x_nxt == '0) && (pix_y_nxt == '0);
      locked_q      <= lock_nxt;
      sync_err_q    <= err_now;
      if (emit) begin
        pix_x_q    <= pix_x_nxt;
        pix_y_q    <= pix_y_nxt;
        pix_data_q <= rgb_q;
      end
      if (line_bad) lines_ok_q <= 1'b0;
      case (state_q)
        SEARCH: if (v_edge) begin
          state_q    <= MEASURE;
          good_cnt_q <= '0;
          lines_ok_q <= 1'b1;
        end
        MEASURE: if (v_edge) begin
          lines_ok_q <= 1'b1;
          if (frame_good) begin
            good_cnt_q <= good_cnt_q + 8'd1;
            if (lock_now) state_q <= LOCKED;
          end else begin
            good_cnt_q <= '0;
          end
        end
        LOCKED: if (err_now) state_q <= SEARCH;
        default: state_q <= SEARCH;
      endcase
    end
  end

  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign pix_data    = pix_data_q;
  assign pix_valid   = pix_valid_q;
  assign frame_start = frame_start_q;
  assign locked      = locked_q;
  assign sync_err    = sync_err_q;

`ifdef VGA_RX_STAT_EN
  logic [10:0] h_meas_q;
  logic [9:0]  v_meas_q;
  logic [7:0]  err_cnt_q;

  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      h_meas_q  <= '0;
      v_meas_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      if (h_edge) h_meas_q <= h_len[11] ? '1 : h_len[10:0];
      if (v_edge) v_meas_q <= v_len[10] ? '1 : v_len[9:0];
      if (err_now && err_cnt_q != '1) err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign h_meas  = h_meas_q;
  assign v_meas  = v_meas_q;
  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_vga_rx.sv
// Scoreboard bench for vga_rx on a shrunken raster: a line/frame-level model
// queues expected pixels and lock/error events, a negedge monitor checks them.
module tb_vga_rx;

  localparam int HS = 4, HA = 6, HV = 8, HT = 16;
  localparam int VA = 3, VV = 4, VT = 10, LF = 2;
  localparam bit POL = 1'b1;

  logic        vga_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        hsync = 1'b0, vsync = 1'b0;
  logic [15:0] vga_rgb = '0;
  logic [9:0]  pix_x, pix_y;
  logic [15:0] pix_data;
  logic        pix_valid, frame_start, locked, sync_err;
`ifdef VGA_RX_STAT_EN
  logic [10:0] h_meas;
  logic [9:0]  v_meas;
  logic [7:0]  err_cnt;
`endif

  vga_rx #(
    .H_SYNC(HS), .H_ACT_START(HA), .H_VALID(HV), .H_TOTAL(HT),
    .V_ACT_START(VA), .V_VALID(VV), .V_TOTAL(VT), .SYNC_POL(POL), .LOCK_FRAMES(LF)
  ) dut (
    .vga_clk(vga_clk), .sys_rst(sys_rst), .hsync(hsync), .vsync(vsync),
    .vga_rgb(vga_rgb), .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data),
    .pix_valid(pix_valid), .frame_start(frame_start), .locked(locked),
    .sync_err(sync_err)
`ifdef VGA_RX_STAT_EN
    , .h_meas(h_meas), .v_meas(v_meas), .err_cnt(err_cnt)
`endif
  );

  always #5 vga_clk = ~vga_clk;

  int cyc = 0;
  always @(posedge vga_clk) cyc++;

  int total = 0, bad = 0;

  typedef struct { logic [9:0] x; logic [9:0] y; logic [15:0] d; int c; } pix_t;
  typedef struct { int c; int tol; } ev_t;
  pix_t pq[$];
  int   lq[$];
  ev_t  eq[$];
  pix_t pe;
  ev_t  ee;
  int   le;
  int   rst_chk = -1;
  bit   mon_en = 1'b0, locked_prev = 1'b0;
  int   n_valid = 0, n_lock = 0, n_err = 0;

  // reference model state (frame/line level)
  int m_state = 0;  // 0 search, 1 measure, 2 locked
  int good = 0, prev_len = 0, frame_lines = 0, last_ls = 0;
  bit lines_ok = 1'b0, has_prev = 1'b0;

  task automatic chk(input string n, input logic [95:0] a, input logic [95:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", n, a, e, cyc);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_valid"}, 96'(pix_valid), 96'(0));
    chk({tag, "_fstart"}, 96'(frame_start), 96'(0));
    chk({tag, "_locked"}, 96'(locked), 96'(0));
    chk({tag, "_syncerr"}, 96'(sync_err), 96'(0));
    chk({tag, "_xydata"}, {pix_x, pix_y, pix_data}, 96'(0));
`ifdef VGA_RX_STAT_EN
    chk({tag, "_errcnt"}, 96'(err_cnt), 96'(0));
`endif
  endtask

  always @(negedge vga_clk) begin
    if (mon_en) begin
      if (cyc == rst_chk) chk_zero_outputs("reset");
      if (pix_valid) begin
        n_valid++;
        if (pq.size() == 0) begin
          total++; bad++;
          $display("FAIL pix_extra: got (%0d,%0d) at cyc %0d, expected no pixel", pix_x, pix_y, cyc);
        end else begin
          pe = pq.pop_front();
          chk("pix", {32'(cyc), pix_x, pix_y, pix_data, frame_start},
                     {32'(pe.c), pe.x, pe.y, pe.d, (pe.x == 10'd0 && pe.y == 10'd0)});
        end
      end else if (frame_start) begin
        total++; bad++;
        $display("FAIL fstart_no_valid: got frame_start=1 at cyc %0d, expected 0", cyc);
      end
      if (locked && !locked_prev) begin
        n_lock++;
        if (lq.size() == 0) begin
          total++; bad++;
          $display("FAIL lock_extra: got lock rise at cyc %0d, expected none", cyc);
        end else begin
          le = lq.pop_front();
          chk("lock_cyc", 96'(cyc), 96'(le));
        end
      end
      if (sync_err) begin
        n_err++;
        chk("unlock_on_err", 96'(locked), 96'(0));
        if (eq.size() == 0) begin
          total++; bad++;
          $display("FAIL err_extra: got sync_err at cyc %0d, expected none", cyc);
        end else begin
          ee = eq.pop_front();
          total++;
          if (cyc < ee.c - ee.tol || cyc > ee.c + ee.tol) begin
            bad++;
            $display("FAIL err_cyc: got %0d expected %0d+-%0d", cyc, ee.c, ee.tol);
          end
        end
      end
      locked_prev = locked;
    end
  end

  // model step at each line start; c is the cycle its first sample is driven
  task automatic model_line_start(input bit is_vs, input int c);
    bit lbad;
    lbad = has_prev && (prev_len != HT);
    case (m_state)
      2: if (lbad || (is_vs && frame_lines != VT)) begin
           eq.push_back('{c + 2, 0});
           m_state = 0;
         end
      1: begin
           if (lbad) lines_ok = 1'b0;
           if (is_vs) begin
             good = (lines_ok && frame_lines == VT) ? good + 1 : 0;
             lines_ok = 1'b1;
             if (good == LF) begin
               m_state = 2;
               lq.push_back(c + 2);
             end
           end
         end
      default: if (is_vs) begin
           m_state = 1; good = 0; lines_ok = 1'b1;
         end
    endcase
    frame_lines = is_vs ? 1 : frame_lines + 1;
  endtask

  task automatic drive_line(input int len, input int row, input bit pat, input int rst_pos);
    logic [9:0]  x, y;
    logic [15:0] d;
    model_line_start(row == 0, cyc);
    last_ls = cyc;
    for (int k = 0; k < len; k++) begin
      x = 10'(k - HA);
      y = 10'(row - VA);
      d = pat ? {y[4:0], x[5:0], y[4:0]} : 16'($urandom);
      hsync   = (k < HS) ? POL : ~POL;
      vsync   = (row < 2) ? POL : ~POL;
      vga_rgb = d;
      sys_rst = (k == rst_pos);
      if (k == rst_pos) begin
        rst_chk = cyc + 1;
        m_state = 0;
      end else if (m_state == 2 && k >= HA && k < HA + HV && row >= VA && row < VA + VV)
        pq.push_back('{x, y, d, cyc + 2});
      @(posedge vga_clk); #1;
    end
    sys_rst  = 1'b0;
    prev_len = len;
    has_prev = (rst_pos < 0);
  endtask

  task automatic drive_frame(input int nlines, input int short_row, input int rst_row, input bit pat);
    for (int r = 0; r < nlines; r++)
      drive_line((r == short_row) ? HT - 1 : HT, r, pat, (r == rst_row) ? 8 : -1);
  endtask

  task automatic drive_gap(input int n);
    hsync = ~POL;
    vsync = ~POL;
    if (m_state == 2) begin
      eq.push_back('{last_ls + 2050, 3});
      m_state = 0;
    end
    has_prev = 1'b0;
    repeat (n) begin
      vga_rgb = 16'($urandom);
      @(posedge vga_clk); #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout at cyc %0d, expected completion", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    sys_rst = 1'b1;
    repeat (3) @(posedge vga_clk);
    #1;
    rst_chk = cyc;
    mon_en  = 1'b1;
    @(negedge vga_clk);
    @(posedge vga_clk); #1;

    for (int f = 0; f < 3; f++) drive_frame(VT, -1, -1, 1'b1);  // lock on third frame
    drive_frame(VT, -1, -1, 1'b0);
    drive_frame(VT, 4, -1, 1'b0);                               // short line while locked
    for (int f = 0; f < 3; f++) drive_frame(VT, -1, -1, 1'b1);  // relock
    drive_frame(VT, -1, -1, 1'b0);
    drive_gap(2100);                                            // hsync loss
    drive_frame(VT, -1, -1, 1'b0);
    drive_frame(VT - 1, -1, -1, 1'b0);                          // wrong frame in MEASURE
    drive_frame(VT, -1, -1, 1'b1);
    drive_frame(VT, -1, -1, 1'b1);
    drive_frame(VT, -1, 8, 1'b1);                               // reset mid-frame
    for (int f = 0; f < 3; f++) drive_frame(VT, -1, -1, 1'b1);
    drive_frame(VT, -1, -1, 1'b0);
    repeat (6) @(posedge vga_clk);
    @(negedge vga_clk); #1;

    chk("pix_left", 96'(pq.size()), 96'(0));
    chk("lock_left", 96'(lq.size()), 96'(0));
    chk("err_left", 96'(eq.size()), 96'(0));
    chk("n_valid", 96'(n_valid), 96'(7 * HV * VV + 2 * HV));
    chk("n_lock", 96'(n_lock), 96'(4));
    chk("n_err", 96'(n_err), 96'(2));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
